// File: rtl/prewitt_window_gen.sv
// Streaming 3x3 window generator feeding the Prewitt kernels.
// Two row line buffers plus a 3x3 shift register; interior centres only.
module prewitt_window_gen #(
    parameter int ROWS  = 242,
    parameter int COLS  = 247,
    parameter int ROW_W = $clog2(ROWS),
    parameter int COL_W = $clog2(COLS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_pixel,
    input  logic             in_sof,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [71:0]      out_window,
    output logic [ROW_W-1:0] out_row,
    output logic [COL_W-1:0] out_col,
    output logic             out_last,
    output logic             sof_err
);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] w_row_eff;
    logic [COL_W-1:0] w_col_eff;
    logic [ROW_W-1:0] w_row_nxt;
    logic [COL_W-1:0] w_col_nxt;
    logic             w_accept;
    logic             w_emit;
    logic             w_row_end;
    logic             w_col_end;
    logic             w_not_origin;

    logic [7:0]       r_lb1 [COLS];
    logic [7:0]       r_lb2 [COLS];
    logic [7:0]       w_lb1_rd;
    logic [7:0]       w_lb2_rd;
    logic [71:0]      r_win;
    logic [71:0]      w_win_nxt;

    logic             r_out_valid;
    logic [71:0]      r_out_window;
    logic [ROW_W-1:0] r_out_row;
    logic [COL_W-1:0] r_out_col;
    logic             r_out_last;
    logic             r_sof_err;

    assign in_ready   = !r_out_valid || out_ready;
    assign w_accept   = in_valid && in_ready;

    // A start-of-frame pixel is always position (0,0).
    assign w_row_eff  = in_sof ? '0 : r_row;
    assign w_col_eff  = in_sof ? '0 : r_col;

    assign w_row_end  = (w_row_eff == ROW_W'(ROWS - 1));
    assign w_col_end  = (w_col_eff == COL_W'(COLS - 1));
    assign w_not_origin = (r_row != '0) || (r_col != '0);

    assign w_emit = w_accept
                 && (w_row_eff >= ROW_W'(2))
                 && (w_col_eff >= COL_W'(2));

    assign w_lb1_rd = r_lb1[w_col_eff];
    assign w_lb2_rd = r_lb2[w_col_eff];

    // Raster position of the pixel after the one being accepted.
    always_comb begin
        w_row_nxt = w_row_eff;
        w_col_nxt = w_col_eff + COL_W'(1);
        if (w_col_end) begin
            w_col_nxt = '0;
            if (w_row_end) begin
                w_row_nxt = '0;
            end else begin
                w_row_nxt = w_row_eff + ROW_W'(1);
            end
        end
    end

    // Shift the window left and insert the new column on the right.
    always_comb begin
        w_win_nxt = r_win;
        for (int k = 0; k < 3; k++) begin
            w_win_nxt[24*k +: 8]      = r_win[24*k + 8 +: 8];
            w_win_nxt[24*k + 8 +: 8]  = r_win[24*k + 16 +: 8];
        end
        w_win_nxt[16 +: 8] = w_lb2_rd;
        w_win_nxt[40 +: 8] = w_lb1_rd;
        w_win_nxt[64 +: 8] = in_pixel;
    end

    // Line buffers and window: pure storage, contents gated by emission.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_win            <= w_win_nxt;
            r_lb2[w_col_eff] <= w_lb1_rd;
            r_lb1[w_col_eff] <= in_pixel;
        end
    end

    // Position counters, output register and sof error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_row        <= '0;
            r_col        <= '0;
            r_out_valid  <= 1'b0;
            r_out_window <= '0;
            r_out_row    <= '0;
            r_out_col    <= '0;
            r_out_last   <= 1'b0;
            r_sof_err    <= 1'b0;
        end else begin
            r_sof_err <= w_accept && in_sof && w_not_origin;
            if (w_accept) begin
                r_row <= w_row_nxt;
                r_col <= w_col_nxt;
            end
            if (w_emit) begin
                r_out_valid  <= 1'b1;
                r_out_window <= w_win_nxt;
                r_out_row    <= w_row_eff - ROW_W'(1);
                r_out_col    <= w_col_eff - COL_W'(1);
                r_out_last   <= w_row_end && w_col_end;
            end else if (out_ready) begin
                r_out_valid  <= 1'b0;
                r_out_last   <= 1'b0;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign out_window = r_out_window;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
    assign out_last   = r_out_last;
    assign sof_err    = r_sof_err;

endmodule

// File: doc/prewitt_window_gen.md
Name: prewitt_window_gen

Overview:
- Streaming 3x3 neighbourhood generator; sits directly upstream of the Prewitt edge kernels (horizontal and vertical).
- Accepts one 8-bit greyscale pixel per handshake, in raster order. Buffers the two previous image rows in line buffers.
- Emits one registered 3x3 window per interior pixel centre, together with the centre coordinates.
- Downstream kernels write 0 at every border position (row 0, row ROWS-1, col 0, col COLS-1); this block never emits border-centred windows.

Parameters:
- ROWS, 242, image height in pixels (>=3)
- COLS, 247, image width in pixels (>=3)
- ROW_W, $clog2(ROWS), width of the row counter and out_row
- COL_W, $clog2(COLS), width of the column counter and out_col

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  in_pixel/in_sof valid
- in_ready  out  1  block can accept a pixel this cycle
- in_pixel  in  8  unsigned pixel, raster order
- in_sof  in  1  marks the first pixel (0,0) of a frame
- out_valid  out  1  out_window/out_row/out_col/out_last valid
- out_ready  in  1  downstream accepts the window
- out_window  out  72  3x3 window; byte index 3*k+m holds window row k (0=top), column m (0=left)
- out_row  out  ROW_W  centre row, 1..ROWS-2
- out_col  out  COL_W  centre column, 1..COLS-2
- out_last  out  1  window centred at (ROWS-2, COLS-2)
- sof_err  out  1  one-cycle pulse: in_sof accepted while position counter is not (0,0)

Behaviour:
- Design is single clock; reset is synchronous and active-high, using ports clk and rst.
- Reset values:
  - out_valid, out_last, sof_err = 0; out_window, out_row, out_col = 0.
  - Row and column counters = 0.
  - Line-buffer RAM and window shift registers are not reset; their contents are don't-care until rows/cols >= 2.
- Handshakes:
  - Accept occurs when in_valid && in_ready.
  - in_ready = !out_valid || out_ready (single output register, combinational ready).
  - Output transfer occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, all outputs hold stable and no input is accepted.
- Position tracking:
  - Counters (r,c) give the position of the next pixel to accept.
  - On accept: c++; when c==COLS-1, c wraps to 0 and r++; when r==ROWS-1 and c==COLS-1, both wrap to 0.
  - If in_sof=1 on accept, the pixel is treated as (0,0) regardless of the counters, and the counters then become (0,1).
  - If in_sof=1 on accept and the counters were not (0,0), sof_err pulses high in the next cycle.
- Line buffers:
  - Two COLS-deep x 8 buffers: LB1 holds row r-1, LB2 holds row r-2.
  - On accept at column c: column vector (top=LB2[c], mid=LB1[c], bot=in_pixel) shifts into the right of the 3x3 register, and the leftmost column is dropped.
  - In the same cycle: LB2[c] <= LB1[c] and LB1[c] <= in_pixel. Use read-before-write semantics.
- Emission:
  - Accepting pixel (r,c) with r>=2 and c>=2 loads the output register in the next cycle.
  - The loaded output is: out_valid=1, out_row=r-1, out_col=c-1, and out_window = the 3x3 register after the shift.
  - out_last=1 iff (r,c)==(ROWS-1,COLS-1).
  - Latency is exactly 1 cycle from accept to out_valid.
  - Accepts with r<2 or c<2 only update state. If the output register is transferred in that cycle, out_valid drops to 0.
  - Emission count per frame is (ROWS-2)*(COLS-2).
- Pixel values pass through unmodified; no arithmetic is performed.
- Reset mid-frame: outputs clear on the next edge, any pending window is discarded, and the counters restart at (0,0).
- Back-to-back frames need no idle cycles; stale line-buffer data from the previous frame is never emitted because emission requires r>=2.

Test Plan:
- ROWS=4, COLS=5, pixel = 10*r+c, in_sof on (0,0), out_ready=1:
  - First out_valid occurs 1 cycle after pixel (2,2) is accepted (the 13th accept), with out_row=1, out_col=1 and window bytes 0..8 = 0,1,2,10,11,12,20,21,22.
  - Exactly 6 windows are emitted, and out_last is set only on (2,3), whose bytes are 12,13,14,22,23,24,32,33,34.
- Same frame with out_ready held 0 for 3 cycles on the first window:
  - out_window and out_valid stay stable and in_ready=0 for those 3 cycles.
  - No pixel is lost: the total is still 6 windows with correct contents.
- Two consecutive frames with no gap (second frame pixel = 100+10*r+c):
  - The second frame's first window contains only second-frame values (100,101,102,...).
  - No sof_err pulse occurs.
- in_sof asserted on accept 7 of a frame:
  - sof_err pulses one cycle.
  - That pixel is treated as (0,0), and the following windows align to the new frame.
- rst asserted after 15 accepts:
  - out_valid=0 and counters are 0 on the next edge.
  - A fresh frame then produces the exact outputs of the first test.
- ROWS=3, COLS=3 (minimum size):
  - A single window (1,1) is emitted with out_last=1, on the cycle after the 9th accept.
